// File: rtl/prog_freq_divider.sv
// Loadable up/down frequency divider: WIDTH-bit counter with terminal-count pulse and 50%-duty output.
// Optional DIV_SHADOW_EN: terminal reload uses a shadow copy of load_val captured only on load.
module prog_freq_divider #(
    parameter int               WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic             dir,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             div_out
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             div_q, div_d;
    logic [WIDTH-1:0] term_val;
    logic [WIDTH-1:0] reload_val;

`ifdef DIV_SHADOW_EN
    logic [WIDTH-1:0] shadow_q, shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        if (load) begin
            shadow_d = load_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= RST_VAL;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign reload_val = shadow_q;
`else
    assign reload_val = load_val;
`endif

    // Terminal value follows the current direction, so a dir flip never lets the count wrap through it.
    assign term_val = dir ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    always_comb begin
        cnt_d = cnt_q;
        tc_d  = 1'b0;
        div_d = div_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en) begin
            if (cnt_q == term_val) begin
                cnt_d = reload_val;
                tc_d  = 1'b1;
                div_d = ~div_q;
            end else if (dir) begin
                cnt_d = cnt_q + WIDTH'(1);
            end else begin
                cnt_d = cnt_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RST_VAL;
            tc_q  <= 1'b0;
            div_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            div_q <= div_d;
        end
    end

    assign cnt     = cnt_q;
    assign tc      = tc_q;
    assign div_out = div_q;

endmodule

// File: tb/tb_prog_freq_divider.sv
// Self-checking bench for prog_freq_divider (WIDTH=8, RST_VAL=0): directed scenarios plus random traffic.
// An arithmetic reference model is compared against the DUT after every clock edge and reset.
module tb_prog_freq_divider;

    localparam int W   = 8;
    localparam int MOD = 1 << W;
`ifdef DIV_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         load = 1'b0;
    logic         dir = 1'b1;
    logic [W-1:0] load_val = '0;
    logic [W-1:0] cnt;
    logic         tc;
    logic         div_out;

    int checks = 0;
    int errors = 0;

    int unsigned m_cnt = 0;
    int unsigned m_shadow = 0;
    bit          m_tc = 1'b0;
    bit          m_div = 1'b0;

    prog_freq_divider #(.WIDTH(W), .RST_VAL('0)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .load     (load),
        .dir      (dir),
        .load_val (load_val),
        .cnt      (cnt),
        .tc       (tc),
        .div_out  (div_out)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic e, input logic l, input logic d, input logic [W-1:0] v);
        en       = e;
        load     = l;
        dir      = d;
        load_val = v;
    endtask

    // Counts edges up to and including the next one that raises tc.
    task automatic measureTc(input int limit, output int edges);
        edges = 0;
        do begin
            @(posedge clk);
            #1;
            edges++;
        end while (tc !== 1'b1 && edges < limit);
        if (tc !== 1'b1) begin
            checks++;
            errors++;
            $display("[TB] FAIL tc_timeout: got no tc within %0d edges", limit);
        end
    endtask

    // Reference model: apply the priority rules to the inputs seen at each edge, then compare.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt    = 0;
            m_shadow = 0;
            m_tc     = 1'b0;
            m_div    = 1'b0;
        end else if (load) begin
            m_cnt    = load_val;
            m_shadow = load_val;
            m_tc     = 1'b0;
        end else if (!en) begin
            m_tc = 1'b0;
        end else if (m_cnt == (dir ? MOD - 1 : 0)) begin
            m_cnt = SHADOW ? m_shadow : int'(load_val);
            m_tc  = 1'b1;
            m_div = !m_div;
        end else begin
            m_cnt = dir ? (m_cnt + 1) % MOD : (m_cnt + MOD - 1) % MOD;
            m_tc  = 1'b0;
        end
        #1;
        checkOutput("model_cnt", cnt, m_cnt);
        checkOutput("model_tc", tc, m_tc);
        checkOutput("model_div", div_out, m_div);
    end

    initial begin
        int  e;
        bit  d1;

        // Reset state and asynchronous mid-count reset.
        applyStimulus(0, 0, 1, 8'h00);
        repeat (2) @(negedge clk);
        checkOutput("reset_cnt", cnt, 0);
        checkOutput("reset_tc", tc, 0);
        checkOutput("reset_div", div_out, 0);
        rst_n = 1'b1;
        applyStimulus(1, 0, 1, 8'h00);
        repeat (144) @(posedge clk);
        #3;
        checkOutput("pre_reset_cnt", cnt, 8'h90);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_cnt", cnt, 0);
        checkOutput("async_reset_tc", tc, 0);
        checkOutput("async_reset_div", div_out, 0);
        @(negedge clk);
        rst_n = 1'b1;
        measureTc(300, e);
        checkOutput("first_tc_after_reset", e, 256);

        // Up count from 0x71.
        @(negedge clk);
        applyStimulus(0, 1, 1, 8'h71);
        @(negedge clk);
        applyStimulus(1, 0, 1, 8'h71);
        measureTc(300, e);
        checkOutput("up_ratio_first", e, 143);
        d1 = div_out;
        measureTc(300, e);
        checkOutput("up_ratio_second", e, 143);
        checkOutput("up_div_toggle", div_out, !d1);

        // Down count from 4.
        @(negedge clk);
        applyStimulus(0, 1, 0, 8'h04);
        @(negedge clk);
        applyStimulus(1, 0, 0, 8'h04);
        measureTc(20, e);
        checkOutput("down_ratio_first", e, 5);
        measureTc(20, e);
        checkOutput("down_ratio_second", e, 5);

        // Enable low: hold, and load still works.
        @(negedge clk);
        applyStimulus(0, 1, 0, 8'h80);
        @(negedge clk);
        checkOutput("load_en_low_cnt", cnt, 8'h80);
        applyStimulus(0, 0, 0, 8'h80);
        repeat (10) @(negedge clk);
        checkOutput("hold_cnt", cnt, 8'h80);
        checkOutput("hold_tc", tc, 0);

        // Ratio 1, then load colliding with a terminal-count edge.
        applyStimulus(0, 1, 1, 8'hFF);
        @(negedge clk);
        applyStimulus(1, 0, 1, 8'hFF);
        for (int i = 0; i < 4; i++) begin
            d1 = div_out;
            measureTc(3, e);
            checkOutput("ratio1_edges", e, 1);
            checkOutput("ratio1_div_toggle", div_out, !d1);
        end
        @(negedge clk);
        applyStimulus(1, 1, 1, 8'hFF);
        d1 = div_out;
        @(posedge clk);
        #1;
        checkOutput("load_wins_tc", tc, 0);
        checkOutput("load_wins_div", div_out, d1);
        checkOutput("load_wins_cnt", cnt, 8'hFF);

        // load_val change without load.
        @(negedge clk);
        applyStimulus(0, 1, 0, 8'h04);
        @(negedge clk);
        applyStimulus(1, 0, 0, 8'h04);
        measureTc(20, e);
        checkOutput("live_change_align", e, 5);
        load_val = 8'h09;
        measureTc(20, e);
        checkOutput("live_change_period1", e, 5);
        measureTc(20, e);
        checkOutput("live_change_period2", e, SHADOW ? 5 : 10);

        // Random traffic against the model.
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            en   = ($urandom_range(0, 9) != 0);
            load = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 99) == 0) dir = ~dir;
            if ($urandom_range(0, 19) == 0) begin
                load_val = dir ? W'($urandom_range(200, 255)) : W'($urandom_range(0, 40));
            end
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
